// File: rtl/seq_result_checker.sv
// seq_result_checker
//   Scoreboard for an upstream top with four DW-bit outputs a/b/c/d.
//   While the checker is idle or done, a program of (signal, cycle, value)
//   entries is written in. After start it walks the entries in order,
//   comparing the selected live output against the expected value at the
//   expected cycle. It counts mismatches and late entries, and it reports
//   done and pass.
//   Optional feature: define CHK_TRACE_EN to add fail_idx/fail_got/fail_vld.
//   These ports capture the first error of each run.
module seq_result_checker #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 10,
    parameter int ERR_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [1:0]       prog_sel,
    input  logic [CW-1:0]    prog_cyc,
    input  logic [DW-1:0]    prog_val,
    input  logic [AW:0]      prog_cnt,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [DW-1:0]    c,
    input  logic [DW-1:0]    d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef CHK_TRACE_EN
    ,
    output logic [AW-1:0]    fail_idx,
    output logic [DW-1:0]    fail_got,
    output logic             fail_vld
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0]    PTR_ONE = 1;
    localparam logic [AW:0]      CNT_ONE = 1;
    localparam logic [CW-1:0]    CYC_ONE = 1;
    localparam logic [ERR_W-1:0] ERR_ONE = 1;

    state_t           state_reg, state_next;
    logic [AW:0]      n_reg, n_next;
    logic [AW-1:0]    ptr_reg, ptr_next;
    logic [CW-1:0]    cyc_reg, cyc_next;
    logic [ERR_W-1:0] err_reg, err_next;

    // Program storage. It has no reset, and it is read asynchronously so that
    // the head entry follows ptr within the same cycle.
    logic [1:0]       mem_sel [DEPTH];
    logic [CW-1:0]    mem_cyc [DEPTH];
    logic [DW-1:0]    mem_val [DEPTH];

    logic [1:0]       head_sel;
    logic [CW-1:0]    head_cyc;
    logic [DW-1:0]    head_val;
    logic [DW-1:0]    obs;
    logic             head_due;
    logic             head_err;
    logic             is_last;
    logic             start_ok;

    // Program writes are accepted only while no run is in progress.
    always_ff @(posedge clk) begin
        if (prog_we && (state_reg != RUN)) begin
            mem_sel[prog_addr] <= prog_sel;
            mem_cyc[prog_addr] <= prog_cyc;
            mem_val[prog_addr] <= prog_val;
        end
    end

    assign head_sel = mem_sel[ptr_reg];
    assign head_cyc = mem_cyc[ptr_reg];
    assign head_val = mem_val[ptr_reg];

    // Select the observed signal that the head entry refers to.
    always_comb begin
        obs = a;
        case (head_sel)
            2'd0:    obs = a;
            2'd1:    obs = b;
            2'd2:    obs = c;
            default: obs = d;
        endcase
    end

    // The head is evaluated once its cycle has arrived. An entry whose cycle
    // has already passed is late, and it counts as one error regardless of its value.
    assign head_due = (cyc_reg >= head_cyc);
    assign head_err = (cyc_reg > head_cyc) || (obs != head_val);
    assign is_last  = ({1'b0, ptr_reg} == (n_reg - CNT_ONE));
    assign start_ok = start && (state_reg != RUN);

    // State and run-context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            ptr_reg   <= '0;
            cyc_reg   <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            ptr_reg   <= ptr_next;
            cyc_reg   <= cyc_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: start/rerun handling and single-entry evaluation per cycle.
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        ptr_next   = ptr_reg;
        cyc_next   = cyc_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    n_next     = prog_cnt;
                    ptr_next   = '0;
                    cyc_next   = '0;
                    err_next   = '0;
                    state_next = (prog_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // The cycle counter pins at all-ones, so late programs still terminate.
                if (cyc_reg != '1) begin
                    cyc_next = cyc_reg + CYC_ONE;
                end
                if (head_due) begin
                    if (head_err && (err_reg != '1)) begin
                        err_next = err_reg + ERR_ONE;
                    end
                    ptr_next = ptr_reg + PTR_ONE;
                    if (is_last) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign pass    = (state_reg == DONE) && (err_reg == '0);
    assign err_cnt = err_reg;

`ifdef CHK_TRACE_EN
    // Capture the index and the observed value of the first error of the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_idx <= '0;
            fail_got <= '0;
            fail_vld <= 1'b0;
        end else if (start_ok) begin
            fail_idx <= '0;
            fail_got <= '0;
            fail_vld <= 1'b0;
        end else if ((state_reg == RUN) && head_due && head_err && !fail_vld) begin
            fail_idx <= ptr_reg;
            fail_got <= obs;
            fail_vld <= 1'b1;
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_seq_result_checker.sv
// Testbench for seq_result_checker. Directed run table plus hand-written
// sequences for rerun, write-during-run, error saturation and async reset.
// A second instance with ERR_W=4 observes the same stimulus for the saturation case.
module tb_seq_result_checker;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 10;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [1:0]    prog_sel;
    logic [CW-1:0] prog_cyc;
    logic [DW-1:0] prog_val;
    logic [AW:0]   prog_cnt;
    logic [DW-1:0] a, b, c, d;
    logic          busy, done, pass;
    logic [7:0]    err_cnt;
    logic          sat_busy, sat_done, sat_pass;
    logic [3:0]    sat_err;
`ifdef CHK_TRACE_EN
    logic [AW-1:0] fail_idx, sat_fail_idx;
    logic [DW-1:0] fail_got, sat_fail_got;
    logic          fail_vld, sat_fail_vld;
`endif

    always #5 clk = ~clk;

    seq_result_checker #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_sel(prog_sel), .prog_cyc(prog_cyc),
        .prog_val(prog_val), .prog_cnt(prog_cnt),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef CHK_TRACE_EN
        , .fail_idx(fail_idx), .fail_got(fail_got), .fail_vld(fail_vld)
`endif
    );

    seq_result_checker #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .ERR_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_sel(prog_sel), .prog_cyc(prog_cyc),
        .prog_val(prog_val), .prog_cnt(prog_cnt),
        .a(a), .b(b), .c(c), .d(d),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_cnt(sat_err)
`ifdef CHK_TRACE_EN
        , .fail_idx(sat_fail_idx), .fail_got(sat_fail_got), .fail_vld(sat_fail_vld)
`endif
    );

    typedef struct {
        int sel;
        int cyc;
        int val;
    } ent_t;

    typedef struct {
        int first;
        int n;
        int va, vb, vc, vd;
        int exp_err;
        int exp_done;
        int fidx;
        int fgot;
    } run_t;

    ent_t ents[32];
    run_t runs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ent(input int i, input int sel, input int cyc, input int val);
        ents[i].sel = sel;
        ents[i].cyc = cyc;
        ents[i].val = val;
    endtask

    task automatic write_entry(input int idx, input int sel, input int cyc, input int val);
        prog_we   = 1'b1;
        prog_addr = idx[AW-1:0];
        prog_sel  = sel[1:0];
        prog_cyc  = cyc[CW-1:0];
        prog_val  = val[DW-1:0];
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic do_start(input int cnt);
        start    = 1'b1;
        prog_cnt = cnt[AW:0];
        tick();
        start    = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen; k equals the run cycle of done.
    task automatic wait_done(input string name, output int k);
        k = 0;
        while (!done && k < 1200) begin
            tick();
            k++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 1200 cycles", name);
        end
    endtask

    task automatic set_obs(input int va, input int vb, input int vc, input int vd);
        a = va[DW-1:0];
        b = vb[DW-1:0];
        c = vc[DW-1:0];
        d = vd[DW-1:0];
    endtask

    initial begin
        int k;
        rst = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_sel = '0;
        prog_cyc = '0; prog_val = '0; prog_cnt = '0;
        set_obs(0, 0, 0, 0);

        // Program pool (sel: 0=a 1=b 2=c 3=d)
        set_ent(0, 2, 2, 48);    set_ent(1, 3, 3, 49);
        set_ent(2, 0, 5, 1);     set_ent(3, 1, 5, 2);
        set_ent(4, 0, 1, 5);     set_ent(5, 1, 2, 6);  set_ent(6, 2, 3, 7); set_ent(7, 3, 4, 8);
        set_ent(8, 0, 4, 1);     set_ent(9, 1, 2, 2);  set_ent(10, 2, 6, 3);
        set_ent(11, 1, 0, 7);
        set_ent(12, 0, 1, 9);    set_ent(13, 0, 1, 9); set_ent(14, 0, 1, 9);
        set_ent(15, 3, 1023, 5); set_ent(16, 3, 1023, 5);

        //          first n  a  b  c   d   err done fidx fgot
        runs[0] = '{0,  2, 0, 0, 48, 49, 0, 4,    0, 0};   // match
        runs[1] = '{0,  2, 0, 0, 48, 50, 1, 4,    1, 50};  // mismatch on d
        runs[2] = '{2,  2, 1, 2, 0,  0,  1, 7,    1, 2};   // second entry late
        runs[3] = '{4,  4, 0, 0, 0,  0,  4, 5,    0, 0};   // all mismatch
        runs[4] = '{8,  3, 1, 2, 3,  0,  1, 7,    1, 2};   // out-of-order entry
        runs[5] = '{11, 1, 0, 7, 0,  0,  0, 1,    0, 0};   // entry at cycle 0
        runs[6] = '{12, 3, 9, 0, 0,  0,  2, 4,    1, 9};   // three entries sharing a cycle
        runs[7] = '{15, 2, 0, 0, 0,  5,  0, 1025, 0, 0};   // pinned cycle counter still matches

        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        rst = 1'b1;
        tick();
        check("idle_done", done, 0);

        // Table-driven runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < runs[r].n; i++) begin
                write_entry(i, ents[runs[r].first + i].sel, ents[runs[r].first + i].cyc,
                            ents[runs[r].first + i].val);
            end
            set_obs(runs[r].va, runs[r].vb, runs[r].vc, runs[r].vd);
            do_start(runs[r].n);
            check($sformatf("run%0d_busy", r), busy, 1);
            check($sformatf("run%0d_err_cleared", r), err_cnt, 0);
            wait_done($sformatf("run%0d", r), k);
            check($sformatf("run%0d_done_cyc", r), k, runs[r].exp_done);
            check($sformatf("run%0d_err", r), err_cnt, runs[r].exp_err);
            check($sformatf("run%0d_pass", r), pass, (runs[r].exp_err == 0) ? 1 : 0);
            check($sformatf("run%0d_busy_low", r), busy, 0);
`ifdef CHK_TRACE_EN
            check($sformatf("run%0d_fail_vld", r), fail_vld, (runs[r].exp_err != 0) ? 1 : 0);
            if (runs[r].exp_err != 0) begin
                check($sformatf("run%0d_fail_idx", r), fail_idx, runs[r].fidx);
                check($sformatf("run%0d_fail_got", r), fail_got, runs[r].fgot);
            end
`endif
            $display("run %0d: done_cyc=%0d err_cnt=%0d pass=%0d", r, k, err_cnt, pass);
        end

        // A write during RUN must not disturb the program
        write_entry(0, 2, 2, 48);
        write_entry(1, 3, 3, 49);
        set_obs(0, 0, 48, 49);
        do_start(2);
        write_entry(1, 3, 3, 99);
        wait_done("we_in_run", k);
        check("we_in_run_err", err_cnt, 0);
        check("we_in_run_pass", pass, 1);
        $display("write-during-run: err_cnt=%0d pass=%0d", err_cnt, pass);

        // Saturation: 16 mismatching entries
        for (int i = 0; i < 16; i++) write_entry(i, 0, i, 255);
        set_obs(0, 0, 0, 0);
        do_start(16);
        wait_done("sat", k);
        check("sat_done_cyc", k, 16);
        check("sat_done_w4", sat_done, 1);
        check("sat_err_w4", sat_err, 15);
        check("sat_pass_w4", sat_pass, 0);
        check("sat_err_w8", err_cnt, 16);
        $display("saturation: err_w4=%0d err_w8=%0d", sat_err, err_cnt);

        // Empty program, then rerun from DONE
        do_start(0);
        check("empty_done", done, 1);
        check("empty_pass", pass, 1);
        check("empty_err", err_cnt, 0);
        check("empty_busy", busy, 0);
        do_start(2);
        check("rerun_busy", busy, 1);
        check("rerun_err", err_cnt, 0);
        wait_done("rerun", k);
        check("rerun_err_final", err_cnt, 2);
        $display("empty+rerun: err_cnt=%0d pass=%0d", err_cnt, pass);

        // Reset in the middle of a 4-entry run
        for (int i = 0; i < 4; i++) write_entry(i, ents[4 + i].sel, ents[4 + i].cyc, ents[4 + i].val);
        set_obs(0, 0, 0, 0);
        do_start(4);
        tick(); tick(); tick();
        check("midrst_err_before", err_cnt, 2);
        check("midrst_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_err", err_cnt, 0);
`ifdef CHK_TRACE_EN
        check("midrst_fail_vld", fail_vld, 0);
`endif
        tick();
        rst = 1'b1;
        tick();

        // Write and start in the same IDLE cycle: entry 0 is replaced before it is read
        set_obs(0, 77, 0, 0);
        prog_we = 1'b1; prog_addr = '0; prog_sel = 2'd1; prog_cyc = 10'd1; prog_val = 8'd77;
        do_start(1);
        prog_we = 1'b0;
        wait_done("we_start", k);
        check("we_start_done_cyc", k, 2);
        check("we_start_err", err_cnt, 0);
        check("we_start_pass", pass, 1);
        $display("reset+new run: done_cyc=%0d err_cnt=%0d pass=%0d", k, err_cnt, pass);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
